// File: rtl/triangle_setup.sv
// triangle_setup
//   Groups the screen-space vertex stream into triangles, computes the signed
//   doubled area and a screen-clamped bounding box, drops degenerate /
//   off-screen / (optionally) back-facing triangles and hands the survivors to
//   the rasterizer over a valid/ready handshake.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_flush               drop a partially collected triangle (COLLECT only)
//   i_vertex_valid/o_vertex_ready, i_x/i_y (Q16.16), i_z, i_u, i_v  vertex in
//   o_tri_valid/i_tri_ready                                         descriptor handshake
//   o_x/o_y {v2,v1,v0} integer pixels, o_z, o_u, o_v {v2,v1,v0}      descriptor data
//   o_area (35-bit signed doubled area), o_bbox_* (clamped, unsigned)
//
// Optional build macro TRI_SETUP_STATS_EN adds o_tri_emitted_cnt and
// o_tri_culled_cnt (16-bit wrapping counters).
module triangle_setup #(
  parameter int SCREEN_W      = 320,
  parameter int SCREEN_H      = 240,
  parameter int CULL_BACKFACE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_vertex_valid,
  output logic        o_vertex_ready,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  input  logic [7:0]  i_z,
  input  logic [31:0] i_u,
  input  logic [31:0] i_v,
  output logic        o_tri_valid,
  input  logic        i_tri_ready,
  output logic [47:0] o_x,
  output logic [47:0] o_y,
  output logic [23:0] o_z,
  output logic [95:0] o_u,
  output logic [95:0] o_v,
  output logic [34:0] o_area,
  output logic [15:0] o_bbox_min_x,
  output logic [15:0] o_bbox_max_x,
  output logic [15:0] o_bbox_min_y,
  output logic [15:0] o_bbox_max_y
`ifdef TRI_SETUP_STATS_EN
  ,
  output logic [15:0] o_tri_emitted_cnt,
  output logic [15:0] o_tri_culled_cnt
`endif
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DIFF    = 2'd1,
    S_AREA    = 2'd2,
    S_EMIT    = 2'd3
  } state_t;

  localparam logic signed [15:0] X_MAX_C = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] Y_MAX_C = 16'(SCREEN_H - 1);
  localparam logic signed [15:0] X_LIM_C = 16'(SCREEN_W);
  localparam logic signed [15:0] Y_LIM_C = 16'(SCREEN_H);

  function automatic logic signed [15:0] smin3(input logic signed [15:0] a,
                                               input logic signed [15:0] b,
                                               input logic signed [15:0] c);
    logic signed [15:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [15:0] smax3(input logic signed [15:0] a,
                                               input logic signed [15:0] b,
                                               input logic signed [15:0] c);
    logic signed [15:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  state_t                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic [2:0][15:0]         x_q, x_d, y_q, y_d;
  logic [2:0][7:0]          z_q, z_d;
  logic [2:0][31:0]         u_q, u_d, v_q, v_d;
  logic signed [16:0]       dx1_q, dx1_d, dy1_q, dy1_d, dx2_q, dx2_d, dy2_q, dy2_d;
  logic signed [15:0]       min_x_q, min_x_d, max_x_q, max_x_d;
  logic signed [15:0]       min_y_q, min_y_d, max_y_q, max_y_d;
  logic signed [34:0]       area_q, area_d;
  logic [15:0]              bb_min_x_q, bb_min_x_d, bb_max_x_q, bb_max_x_d;
  logic [15:0]              bb_min_y_q, bb_min_y_d, bb_max_y_q, bb_max_y_d;
  logic                     off_q, off_d;
  logic                     tri_valid_q, tri_valid_d;

  logic                     accept_s, drop_s, hs_s, drop_evt_s;
  logic signed [34:0]       prod1_s, prod2_s;

  // Flush wins over a simultaneous vertex, so it also masks ready.
  assign o_vertex_ready = (state_q == S_COLLECT) && !i_flush;
  assign accept_s       = i_vertex_valid && o_vertex_ready;
  assign drop_s         = (area_q == 35'sd0) || off_q ||
                          ((CULL_BACKFACE != 0) && area_q[34]);
  assign hs_s           = tri_valid_q && i_tri_ready;
  assign drop_evt_s     = (state_q == S_EMIT) && !tri_valid_q && drop_s;

  // Cross products at full 35-bit width; the exact result always fits.
  assign prod1_s = $signed({{18{dx1_q[16]}}, dx1_q}) * $signed({{18{dy2_q[16]}}, dy2_q});
  assign prod2_s = $signed({{18{dx2_q[16]}}, dx2_q}) * $signed({{18{dy1_q[16]}}, dy1_q});

  // Next-state and datapath update for the collect/diff/area/emit pipeline.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    u_d         = u_q;
    v_d         = v_q;
    dx1_d       = dx1_q;
    dy1_d       = dy1_q;
    dx2_d       = dx2_q;
    dy2_d       = dy2_q;
    min_x_d     = min_x_q;
    max_x_d     = max_x_q;
    min_y_d     = min_y_q;
    max_y_d     = max_y_q;
    area_d      = area_q;
    bb_min_x_d  = bb_min_x_q;
    bb_max_x_d  = bb_max_x_q;
    bb_min_y_d  = bb_min_y_q;
    bb_max_y_d  = bb_max_y_q;
    off_d       = off_q;
    tri_valid_d = tri_valid_q;
    case (state_q)
      S_COLLECT: begin
        if (i_flush) begin
          idx_d = 2'd0;
        end else if (accept_s) begin
          x_d[idx_q] = i_x[31:16];
          y_d[idx_q] = i_y[31:16];
          z_d[idx_q] = i_z;
          u_d[idx_q] = i_u;
          v_d[idx_q] = i_v;
          if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            state_d = S_DIFF;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_DIFF: begin
        dx1_d   = {x_q[1][15], x_q[1]} - {x_q[0][15], x_q[0]};
        dy1_d   = {y_q[1][15], y_q[1]} - {y_q[0][15], y_q[0]};
        dx2_d   = {x_q[2][15], x_q[2]} - {x_q[0][15], x_q[0]};
        dy2_d   = {y_q[2][15], y_q[2]} - {y_q[0][15], y_q[0]};
        min_x_d = smin3(x_q[0], x_q[1], x_q[2]);
        max_x_d = smax3(x_q[0], x_q[1], x_q[2]);
        min_y_d = smin3(y_q[0], y_q[1], y_q[2]);
        max_y_d = smax3(y_q[0], y_q[1], y_q[2]);
        state_d = S_AREA;
      end
      S_AREA: begin
        area_d     = prod1_s - prod2_s;
        bb_min_x_d = min_x_q[15] ? 16'd0 : min_x_q;
        bb_min_y_d = min_y_q[15] ? 16'd0 : min_y_q;
        bb_max_x_d = (max_x_q > X_MAX_C) ? X_MAX_C : max_x_q;
        bb_max_y_d = (max_y_q > Y_MAX_C) ? Y_MAX_C : max_y_q;
        off_d      = max_x_q[15] || max_y_q[15] ||
                     (min_x_q >= X_LIM_C) || (min_y_q >= Y_LIM_C);
        state_d    = S_EMIT;
      end
      S_EMIT: begin
        // First EMIT cycle decides; afterwards the descriptor is held until taken.
        if (hs_s) begin
          tri_valid_d = 1'b0;
          state_d     = S_COLLECT;
        end else if (drop_evt_s) begin
          state_d = S_COLLECT;
        end else begin
          tri_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  // Pipeline and FSM registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_COLLECT;
      idx_q       <= 2'd0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      u_q         <= '0;
      v_q         <= '0;
      dx1_q       <= 17'sd0;
      dy1_q       <= 17'sd0;
      dx2_q       <= 17'sd0;
      dy2_q       <= 17'sd0;
      min_x_q     <= 16'sd0;
      max_x_q     <= 16'sd0;
      min_y_q     <= 16'sd0;
      max_y_q     <= 16'sd0;
      area_q      <= 35'sd0;
      bb_min_x_q  <= 16'd0;
      bb_max_x_q  <= 16'd0;
      bb_min_y_q  <= 16'd0;
      bb_max_y_q  <= 16'd0;
      off_q       <= 1'b0;
      tri_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      u_q         <= u_d;
      v_q         <= v_d;
      dx1_q       <= dx1_d;
      dy1_q       <= dy1_d;
      dx2_q       <= dx2_d;
      dy2_q       <= dy2_d;
      min_x_q     <= min_x_d;
      max_x_q     <= max_x_d;
      min_y_q     <= min_y_d;
      max_y_q     <= max_y_d;
      area_q      <= area_d;
      bb_min_x_q  <= bb_min_x_d;
      bb_max_x_q  <= bb_max_x_d;
      bb_min_y_q  <= bb_min_y_d;
      bb_max_y_q  <= bb_max_y_d;
      off_q       <= off_d;
      tri_valid_q <= tri_valid_d;
    end
  end

  assign o_tri_valid  = tri_valid_q;
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_z          = z_q;
  assign o_u          = u_q;
  assign o_v          = v_q;
  assign o_area       = area_q;
  assign o_bbox_min_x = bb_min_x_q;
  assign o_bbox_max_x = bb_max_x_q;
  assign o_bbox_min_y = bb_min_y_q;
  assign o_bbox_max_y = bb_max_y_q;

`ifdef TRI_SETUP_STATS_EN
  logic [15:0] emitted_cnt_q, emitted_cnt_d, culled_cnt_q, culled_cnt_d;

  // Wrapping event counters for transferred and dropped triangles.
  always_comb begin
    emitted_cnt_d = emitted_cnt_q;
    culled_cnt_d  = culled_cnt_q;
    if (hs_s) begin
      emitted_cnt_d = emitted_cnt_q + 16'd1;
    end else begin
      emitted_cnt_d = emitted_cnt_q;
    end
    if (drop_evt_s) begin
      culled_cnt_d = culled_cnt_q + 16'd1;
    end else begin
      culled_cnt_d = culled_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      emitted_cnt_q <= 16'd0;
      culled_cnt_q  <= 16'd0;
    end else begin
      emitted_cnt_q <= emitted_cnt_d;
      culled_cnt_q  <= culled_cnt_d;
    end
  end

  assign o_tri_emitted_cnt = emitted_cnt_q;
  assign o_tri_culled_cnt  = culled_cnt_q;
`endif

endmodule

// File: doc/triangle_setup.md
Name: triangle_setup

Overview:
- Sits directly downstream of the geometry engine's vertex FIFO and consumes its screen-space vertex stream (x/y Q16.16 pixel coordinates, 8-bit depth, u/v).
- Groups every three accepted vertices into one triangle and computes the signed doubled area (edge-function determinant) and a screen-clamped bounding box.
- Drops degenerate, off-screen and (optionally) back-facing triangles.
- Passes each surviving triangle to the rasterizer over a valid/ready handshake.

Parameters:
- SCREEN_W, 320, horizontal resolution in pixels; bbox x clamp is [0, SCREEN_W-1].
- SCREEN_H, 240, vertical resolution in pixels; bbox y clamp is [0, SCREEN_H-1].
- CULL_BACKFACE, 1, when 1, triangles with negative area are dropped.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_flush  in  1  discard any partially collected triangle (frame boundary / vertex dropped upstream).
- i_vertex_valid  in  1  FIFO output holds a vertex.
- o_vertex_ready  out  1  block accepts a vertex this cycle (FIFO pop).
- i_x, i_y  in  32 each  Q16.16 screen coordinates; integer part [31:16], signed.
- i_z  in  8  depth.
- i_u, i_v  in  32 each  texture coordinates, passed through untouched.
- o_tri_valid  out  1  triangle descriptor valid.
- i_tri_ready  in  1  rasterizer accepts the descriptor.
- o_x  out  48  {x2,x1,x0}, signed 16-bit integer pixel coordinates.
- o_y  out  48  {y2,y1,y0}, signed 16-bit integer pixel coordinates.
- o_z  out  24  {z2,z1,z0}.
- o_u, o_v  out  96 each  {w2,w1,w0}.
- o_area  out  35  signed doubled area.
- o_bbox_min_x, o_bbox_max_x  out  16  clamped, unsigned.
- o_bbox_min_y, o_bbox_max_y  out  16  clamped, unsigned.

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is synchronous and active-high.
- Reset values: state S_COLLECT, vertex index 0, o_tri_valid 0, all data outputs 0. o_vertex_ready is 1 from the first cycle after reset.
- Vertex acceptance:
  - A vertex is accepted when i_vertex_valid && o_vertex_ready.
  - Only the integer part [31:16] of x/y is stored.
  - Vertex index counts 0, 1, 2 and wraps to 0.
- States:
  - S_COLLECT: o_vertex_ready=1. Each accepted vertex is stored into slot[index]. Accepting slot 2 moves to S_DIFF.
  - S_DIFF (1 cycle): registers 17-bit signed dx1=x1-x0, dy1=y1-y0, dx2=x2-x0, dy2=y2-y0, plus raw signed min/max of x and y.
  - S_AREA (1 cycle):
    - area = dx1*dy2 - dx2*dy1, computed at full 35-bit signed width with no truncation.
    - bbox clamped: min to max(min,0); max_x to min(max_x,SCREEN_W-1); max_y to min(max_y,SCREEN_H-1).
    - Off-screen flag set when raw max_x<0, max_y<0, min_x>=SCREEN_W or min_y>=SCREEN_H.
  - S_EMIT:
    - If area==0, or off-screen, or (CULL_BACKFACE && area<0): o_tri_valid stays 0 and the FSM returns to S_COLLECT next cycle.
    - Otherwise o_tri_valid=1 and all descriptor outputs are driven from registers.
    - o_tri_valid and all descriptor outputs hold stable until i_tri_ready. On valid&&ready the FSM returns to S_COLLECT; o_tri_valid=0 the next cycle.
- Latency: third vertex accepted at edge T gives o_tri_valid=1 from T+3. A culled triangle gives o_vertex_ready=1 again at T+3.
- Flow control: o_vertex_ready=0 in S_DIFF, S_AREA and S_EMIT, so the FIFO back-pressures and no vertex is lost.
- Orientation: area>0 is front-facing (screen y points down).
- Flush:
  - In S_COLLECT, i_flush clears the index to 0 and has priority over a simultaneous accept; that vertex is not consumed (ready is forced 0 that cycle).
  - In any other state, flush is ignored and the in-flight triangle completes.
- Reset mid-handshake: o_tri_valid drops the next cycle and the descriptor is lost; this is acceptable.

Optional Feature:
- Macro: TRI_SETUP_STATS_EN.
- Defined:
  - Adds outputs o_tri_emitted_cnt[15:0] and o_tri_culled_cnt[15:0].
  - Emitted increments on each valid&&ready. Culled increments once per triangle dropped in S_EMIT.
  - Both wrap at 0xFFFF→0 and reset to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Vertices (10,10),(50,10),(10,40) (x=0x000A0000, etc.), i_tri_ready=1 → one triangle 3 cycles after the third accept: area=1200, bbox x 10..50, y 10..40, z/u/v passed through in slot order.
2. Same vertices in order v0,v2,v1 → CULL_BACKFACE=1: no o_tri_valid and ready returns at T+3. CULL_BACKFACE=0: emitted with area=-1200.
3. Collinear (0,0),(10,10),(20,20) → area 0, culled. Three x=-20 (0xFFEC0000) vertices → off-screen, culled. Vertex x=400 with others in range → bbox max_x=319.
4. Emit a triangle with i_tri_ready=0 for 5 cycles while the FIFO holds more vertices → outputs stable, o_vertex_ready=0 throughout. Ready high → exactly one transfer and collection resumes.
5. Accept 2 vertices, pulse i_flush together with a valid third vertex → vertex not consumed, index 0. The next 3 vertices form a correct triangle.
6. With TRI_SETUP_STATS_EN: 3 emitted + 2 culled triangles → counters read 3 and 2. Assert i_rst → both 0, o_tri_valid 0, o_vertex_ready 1 the cycle after.
